// File: rtl/mac_tx_queue_arb_if.sv
// mac_tx_queue_arb_if
//   MAC transmit byte stream between the queue scheduler and the MAC.
//   master : scheduler side (drives tx_valid/tx_data/tx_sof/tx_eof/tx_chan)
//   slave  : MAC side (drives tx_ready)
//   tx_valid  byte valid        tx_ready  MAC accepts the byte this cycle
//   tx_data   frame byte        tx_sof    first byte of frame (with tx_valid)
//   tx_eof    last byte (with tx_valid)   tx_chan   queue index of the frame
interface mac_tx_queue_arb_if #(
    parameter int CW = 1
) ();
    logic          tx_valid;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_sof;
    logic          tx_eof;
    logic [CW-1:0] tx_chan;

    modport master (output tx_valid, tx_data, tx_sof, tx_eof, tx_chan, input tx_ready);
    modport slave  (input tx_valid, tx_data, tx_sof, tx_eof, tx_chan, output tx_ready);
endinterface

// File: rtl/mac_tx_queue_arb.sv
// mac_tx_queue_arb
//   N-queue transmit scheduler. Picks an eligible queue (strict priority or
//   round-robin), reads the frame length from its pointer FIFO, then streams
//   exactly that many bytes from its data FIFO to the MAC, followed by a
//   minimum inter-frame gap of IFG_CYCLES clocks.
//   Optional macro ARB_GATE_EN adds per-queue gate_open inputs that qualify
//   eligibility at the arbitration point.
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   ptr_fifo_empty   per-queue pointer FIFO empty
//   ptr_fifo_rd      per-queue pointer FIFO read strobe (one-hot or zero)
//   ptr_fifo_din     per-queue pointer word, queue q at [16q+15:16q]
//   data_fifo_rd     per-queue data FIFO read strobe (one-hot or zero)
//   data_fifo_din    per-queue data byte, queue q at [8q+7:8q]
//   gate_open        per-queue transmission gate (ARB_GATE_EN only)
//   tx               MAC byte stream (master side)
//   busy             high from the pointer read until the eof byte is taken
// FIFOs are standard read: din is valid the cycle after rd.
module mac_tx_queue_arb #(
    parameter int N_QUEUE    = 2,
    parameter int CW         = 1,
    parameter int ARB_MODE   = 0,
    parameter int IFG_CYCLES = 12,
    parameter int LEN_W      = 11
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_QUEUE-1:0]     ptr_fifo_empty,
    output logic [N_QUEUE-1:0]     ptr_fifo_rd,
    input  logic [16*N_QUEUE-1:0]  ptr_fifo_din,
    output logic [N_QUEUE-1:0]     data_fifo_rd,
    input  logic [8*N_QUEUE-1:0]   data_fifo_din,
`ifdef ARB_GATE_EN
    input  logic [N_QUEUE-1:0]     gate_open,
`endif
    mac_tx_queue_arb_if.master     tx,
    output logic                   busy
);
    localparam int GW = $clog2(IFG_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, PLEN, DATA} state_t;
    state_t state, state_nx;

    logic [N_QUEUE-1:0] elig;
    logic               win_found;
    logic [CW-1:0]      win;
    int                 idx;
    logic [CW-1:0]      chan, rr_last;
    logic [GW-1:0]      gap;
    logic [LEN_W-1:0]   len, remaining, out_cnt, plen;
    logic [1:0][7:0]    sbuf, sbuf_nx;
    logic [1:0]         cnt, cnt_nx;
    logic               inflight;
    logic [7:0]         din_byte;
    logic               start, issue, vld, accept, eof, eof_acc;
    logic               unused_ok;

`ifdef ARB_GATE_EN
    assign elig = ~ptr_fifo_empty & gate_open;
`else
    assign elig = ~ptr_fifo_empty;
`endif

    // Only the low LEN_W bits of each pointer word carry the length.
    assign unused_ok = ^ptr_fifo_din;

    // Winner search: index order for strict mode, otherwise starting one past
    // the last served queue.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        idx       = 0;
        for (int i = 0; i < N_QUEUE; i++) begin
            idx = (ARB_MODE == 0) ? i : (int'(rr_last) + 1 + i) % N_QUEUE;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win       = CW'(idx);
            end
        end
    end

    assign plen     = ptr_fifo_din[16*int'(chan) +: LEN_W];
    assign din_byte = data_fifo_din[8*int'(chan) +: 8];
    assign start    = (state == IDLE) && (gap == '0) && win_found;

    // A read may only be issued if the skid can hold its byte even when the
    // MAC stalls: buffered plus in-flight bytes never exceed two.
    assign issue = (state == DATA) && (remaining != '0) &&
                   ((cnt + {1'b0, inflight}) < 2'd2);

    // The returning byte is presented directly when the skid is empty, so the
    // first byte appears in the same cycle it comes out of the data FIFO.
    assign vld     = (cnt != 2'd0) || inflight;
    assign eof     = vld && (out_cnt == len - 1'b1);
    assign accept  = vld && tx.tx_ready;
    assign eof_acc = accept && eof;

    assign tx.tx_valid = vld;
    assign tx.tx_data  = (cnt != 2'd0) ? sbuf[0] : (inflight ? din_byte : 8'h00);
    assign tx.tx_sof   = vld && (out_cnt == '0);
    assign tx.tx_eof   = eof;
    assign tx.tx_chan  = chan;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = PLEN;
            PLEN:    state_nx = (plen == '0) ? IDLE : DATA;
            DATA:    if (eof_acc) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ptr_fifo_rd  = '0;
        data_fifo_rd = '0;
        if (start) ptr_fifo_rd[win]   = 1'b1;
        if (issue) data_fifo_rd[chan] = 1'b1;
        busy = (state != IDLE) || start;
    end

    // Skid: pop the head on accept, then append a returning byte unless it
    // went straight out to the MAC.
    always_comb begin
        sbuf_nx = sbuf;
        cnt_nx  = cnt;
        if (accept && cnt != 2'd0) begin
            sbuf_nx[0] = sbuf[1];
            cnt_nx     = cnt - 2'd1;
        end
        if (inflight && !(accept && cnt == 2'd0)) begin
            sbuf_nx[cnt_nx[0]] = din_byte;
            cnt_nx             = cnt_nx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chan      <= '0;
            rr_last   <= CW'(N_QUEUE - 1);
            gap       <= '0;
            len       <= '0;
            remaining <= '0;
            out_cnt   <= '0;
            sbuf      <= '0;
            cnt       <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            if (gap != '0) gap <= gap - 1'b1;
            if (start) begin
                chan    <= win;
                rr_last <= win;
            end
            if (state == PLEN) begin
                len       <= plen;
                remaining <= plen;
                out_cnt   <= '0;
                if (plen == '0) gap <= GW'(IFG_CYCLES);
            end
            if (issue)   remaining <= remaining - 1'b1;
            inflight <= issue;
            sbuf     <= sbuf_nx;
            cnt      <= cnt_nx;
            if (accept)  out_cnt <= out_cnt + 1'b1;
            if (eof_acc) gap <= GW'(IFG_CYCLES);
        end
    end
endmodule

// File: doc/mac_tx_queue_arb.md
Name: mac_tx_queue_arb

Overview:
- Parametrised N-queue transmit scheduler. Sits between the per-queue data/pointer FIFO pairs and the MAC transmit byte interface.
- Generalises the existing fixed two-queue arrangement (one normal queue and one TTE queue) to N_QUEUE queues.
- Selects a queue by strict priority or round-robin, reads the frame length from that queue's pointer FIFO, then streams exactly that many bytes from its data FIFO to the MAC over a valid/ready handshake.
- Enforces a programmable minimum inter-frame idle gap.

Parameters:
- N_QUEUE, 2, number of queues; queue 0 is highest priority (TTE queue).
- CW, 1, width of the queue index; must satisfy 2^CW >= N_QUEUE.
- ARB_MODE, 0, 0 = strict priority (lowest index wins); 1 = round-robin starting after the last served queue.
- IFG_CYCLES, 12, minimum clk cycles between tx_eof accepted and the next ptr_fifo_rd.
- LEN_W, 11, width of the length field, taken from ptr_fifo_din[LEN_W-1:0].

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- ptr_fifo_empty  in  N_QUEUE  per-queue pointer FIFO empty flag.
- ptr_fifo_rd  out  N_QUEUE  per-queue pointer FIFO read strobe.
- ptr_fifo_din  in  16*N_QUEUE  per-queue pointer word; queue q occupies bits [16q+15:16q].
- data_fifo_rd  out  N_QUEUE  per-queue data FIFO read strobe.
- data_fifo_din  in  8*N_QUEUE  per-queue data byte; queue q occupies bits [8q+7:8q].
- gate_open  in  N_QUEUE  per-queue transmission gate. Present only with ARB_GATE_EN.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  MAC accepts the byte this cycle.
- tx_data  out  8  frame byte.
- tx_sof  out  1  marks the first byte of a frame; qualified by tx_valid.
- tx_eof  out  1  marks the last byte of a frame; qualified by tx_valid.
- tx_chan  out  CW  queue index of the frame currently being sent.
- busy  out  1  high from the ptr read until the eof byte is accepted.

Behaviour:
- Interface decision: one clock, clk; reset rstn is asynchronous and active-low.
- Reset: all outputs 0, FSM to IDLE, skid buffer emptied, gap counter 0, round-robin pointer set so queue 0 has first priority.
- Reset mid-frame: the frame is abandoned immediately and tx_valid drops at once. The FIFOs are reset by the same reset, so no resynchronisation is needed.
- FIFO model: standard (non-FWFT) read. din is valid the cycle after rd is asserted.
- A queue is eligible when !ptr_fifo_empty[q], and also gate_open[q] when ARB_GATE_EN is defined.
- FSM:
  - IDLE: if gap counter == 0 and any queue is eligible, pick the winner per ARB_MODE, assert ptr_fifo_rd[winner] for exactly 1 cycle, latch tx_chan, go to PLEN.
  - PLEN: capture len = ptr_fifo_din[winner][LEN_W-1:0]. If len == 0, discard the pointer, stream nothing, load the gap counter, and go to IDLE. Otherwise load remaining = len and go to DATA.
  - DATA:
    - Issue data_fifo_rd[winner] when remaining > 0 and (skid occupancy + reads in flight) < 2. Each issued read decrements remaining.
    - Returned bytes enter a 2-entry skid buffer that drives tx_data/tx_valid.
    - The first byte emitted carries tx_sof. The byte whose count equals len carries tx_eof.
    - The entry is removed when tx_valid && tx_ready.
    - When the eof byte is accepted: load the gap counter with IFG_CYCLES and go to IDLE.
  - The gap counter decrements every cycle while non-zero.
- Throughput: with tx_ready held high, 1 byte per cycle after startup.
  - Latency from ptr_fifo_rd to the first tx_valid is 3 cycles: PLEN, data read issue, byte return.
- The arbitration decision is made only in IDLE and is not preempted mid-frame. A higher-priority queue becoming eligible during a frame waits.
- len == 1: tx_sof and tx_eof are asserted on the same byte.
- tx_ready held low stalls output. tx_valid, tx_data, tx_sof and tx_eof hold stable, and no more than 2 data reads are outstanding or buffered.
- Round-robin (ARB_MODE = 1): the search starts at (last served + 1) mod N_QUEUE. The pointer updates only when a frame's ptr read is issued; a len == 0 discard counts as service.
- Multiple queues eligible in the same cycle: strict mode picks the lowest index; round-robin picks the first index in search order.
- data_fifo_rd and ptr_fifo_rd are one-hot or zero and never asserted in the same cycle.

Optional Feature:
- ARB_GATE_EN defined: gate_open port is present. A queue is eligible only while its gate bit is high in IDLE. Closing the gate mid-frame does not truncate the frame.
- ARB_GATE_EN undefined: gate_open port is absent and every queue is treated as gated open.

Test Plan:
- N_QUEUE=2, ARB_MODE=0, queue1 loaded with lens 60 and 1514 bytes, tx_ready=1 -> two frames on tx_chan=1 of exactly 60 and 1514 bytes, byte-exact against the written data, with sof/eof on the correct bytes and ≥12 idle cycles between them.
- Both queues hold a 100-byte frame at the same time, strict mode -> queue 0 is sent first. A queue-0 frame written while the queue-1 frame is in progress waits until eof plus the gap.
- ARB_MODE=1, N_QUEUE=4, all queues each hold three 64-byte frames -> tx_chan sequence 0,1,2,3,0,1,2,3,0,1,2,3.
- len=1 and len=0 frames on queue 0 -> the 1-byte frame has sof=eof=1. The len=0 frame produces no tx_valid and no data_fifo_rd, and the following 58-byte frame is intact.
- tx_ready toggled pseudo-randomly at 30% duty during a 300-byte frame -> no lost or duplicated bytes, outputs stable while stalled, never more than 2 bytes outstanding. Then rstn pulsed low mid-frame -> all outputs 0 immediately.
- ARB_GATE_EN, gate_open[0]=0 with both queues loaded -> only queue 1 is served. Raising gate_open[0] -> queue 0 is served at the next IDLE decision.
